// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and affine transforms for the S-box blocks.
package aes_pkg;

  localparam logic [7:0] GF_POLY   = 8'h1B;
  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_e;

  // y_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ c_i, undoing the forward affine map
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ INV_AFF_C[i];
    end
    return y;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    logic [7:0] y;
    y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ AFF_C[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier: shift-and-add with reduction on carry-out.
module gf256_mul #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] x;

  // eight iterations: accumulate a*x^i for each set bit of b, reducing x as it doubles
  always_comb begin
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ x;
      end else begin
        acc = acc;
      end
      if (x[7]) begin
        x = {x[6:0], 1'b0} ^ POLY;
      end else begin
        x = {x[6:0], 1'b0};
      end
    end
    p = acc;
  end

endmodule

// File: rtl/aes_inv_sbox_seq.sv
// Sequential AES inverse S-box: inverse affine map, then a^254 by square-and-multiply
// on one shared GF(2^8) multiplier, with valid/ready on both sides.
module aes_inv_sbox_seq #(
  parameter logic [7:0] GF_POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  import aes_pkg::*;

  state_e     state_r, state_s;
  logic [3:0] step_r, step_s;
  logic [7:0] a_r, a_s;
  logic [7:0] r_r, r_s;
  logic       out_valid_r, out_valid_s;
  logic [7:0] out_data_r, out_data_s;
  logic [7:0] mul_b_s;
  logic [7:0] prod_s;

  // exponent 11111110 MSB-first: even steps square, odd steps multiply by a
  assign mul_b_s = step_r[0] ? a_r : r_r;

  gf256_mul #(
    .POLY(GF_POLY)
  ) u_mul (
    .a(r_r),
    .b(mul_b_s),
    .p(prod_s)
  );

  // next-state and datapath update
  always_comb begin
    state_s     = state_r;
    step_s      = step_r;
    a_s         = a_r;
    r_s         = r_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s     = inv_affine(in_data);
          r_s     = inv_affine(in_data);
          step_s  = 4'd0;
          state_s = COMP;
        end else begin
          state_s = IDLE;
        end
      end
      COMP: begin
        r_s = prod_s;
        if (step_r == LAST_STEP) begin
          out_data_s  = prod_s;
          out_valid_s = 1'b1;
          step_s      = 4'd0;
          state_s     = DONE;
        end else begin
          step_s = step_r + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      step_r      <= 4'd0;
      a_r         <= 8'h00;
      r_r         <= 8'h00;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      state_r     <= state_s;
      step_r      <= step_s;
      a_r         <= a_s;
      r_r         <= r_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Self-checking bench for aes_inv_sbox_seq against a brute-force GF inverse reference.
module tb_aes_inv_sbox_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] inv_tbl [256];

  aes_inv_sbox_seq #(.GF_POLY(8'h1B)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // polynomial product then long division by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    logic [15:0] m;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'({8'h00, x}) << i);
    for (int i = 15; i >= 8; i--) begin
      m = 16'h011B;
      if (p[i]) p = p ^ (m << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] b, input int n);
    return (b >> n) | (b << (8 - n));
  endfunction

  function automatic logic [7:0] model_inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    y = rotr(b, 2) ^ rotr(b, 5) ^ rotr(b, 7) ^ 8'h05;
    return inv_tbl[y];
  endfunction

  function automatic logic [7:0] model_fwd_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = inv_tbl[b];
    return x ^ rotr(x, 7) ^ rotr(x, 6) ^ rotr(x, 5) ^ rotr(x, 4) ^ 8'h63;
  endfunction

  task automatic build_tables();
    inv_tbl[0] = 8'h00;
    for (int x = 1; x < 256; x++) begin
      inv_tbl[x] = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(8'(x), 8'(j)) == 8'h01) inv_tbl[x] = 8'(j);
    end
  endtask

  // wait (bounded) for in_ready, present b for one accept edge
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count cycles from the accept edge until out_valid is seen
  task automatic wait_result(output logic [7:0] d, output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    d = out_data;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_result timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h required 00", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [7:0] vin [5]  = '{8'h63, 8'h7C, 8'h00, 8'hFF, 8'hED};
    logic [7:0] vexp [5] = '{8'h00, 8'h01, 8'h52, 8'h7D, 8'h53};
    logic [7:0] d;
    int lat;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(vin[k]);
      wait_result(d, lat);
      checks += 2;
      if (d !== vexp[k]) begin errors++; $display("FAIL known_data in=%h: got %h required %h", vin[k], d, vexp[k]); end
      if (lat !== 13) begin errors++; $display("FAIL known_latency in=%h: got %0d required 13", vin[k], lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int lat;
    out_ready = 1'b0;
    send(8'h7C);
    wait_result(d, lat);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d: got %b required 1", k, out_valid); end
      if (out_data !== 8'h01) begin errors++; $display("FAIL stall_data cyc=%0d: got %h required 01", k, out_data); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d: got %b required 0", k, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b required 0", out_valid); end
    if (out_data !== 8'h01) begin errors++; $display("FAIL release_out_data_hold: got %h required 01", out_data); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    int lat;
    out_ready = 1'b1;
    send(8'h63);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    wait_result(d, lat);
    checks += 2;
    if (d !== 8'h00) begin errors++; $display("FAIL busy_first_data: got %h required 00", d); end
    if (lat !== 13) begin errors++; $display("FAIL busy_first_latency: got %0d required 13", lat); end
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_single_result: out_valid=%b required 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_back_idle: in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(d, lat);
    checks += 2;
    if (d !== 8'h7D) begin errors++; $display("FAIL busy_second_data: got %h required 7d", d); end
    if (lat !== 13) begin errors++; $display("FAIL busy_second_latency: got %0d required 13", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int lat;
    logic seen;
    out_ready = 1'b1;
    send(8'h00);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b required 1", in_ready); end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_output: out_valid seen=%b required 0", seen); end
    send(8'h16);
    wait_result(d, lat);
    checks += 2;
    if (d !== 8'hFF) begin errors++; $display("FAIL midreset_next_data: got %h required ff", d); end
    if (lat !== 13) begin errors++; $display("FAIL midreset_next_latency: got %0d required 13", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] exp_d;
    int lat;
    int stall;
    for (int i = 0; i < 256; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(8'(i));
      wait_result(d, lat);
      exp_d = model_inv_sbox(8'(i));
      checks += 3;
      if (d !== exp_d) begin errors++; $display("FAIL sweep_data in=%h: got %h required %h", i[7:0], d, exp_d); end
      if (model_fwd_sbox(d) !== 8'(i)) begin errors++; $display("FAIL sweep_roundtrip in=%h: sbox(%h)=%h required %h", i[7:0], d, model_fwd_sbox(d), i[7:0]); end
      if (lat !== 13) begin errors++; $display("FAIL sweep_latency in=%h: got %0d required 13", i[7:0], lat); end
      if (!out_ready) begin
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++) begin
          @(posedge clk); #1;
          checks++;
          if (out_valid !== 1'b1 || out_data !== d) begin
            errors++;
            $display("FAIL sweep_stall_hold in=%h: valid=%b data=%h required 1 %h", i[7:0], out_valid, out_data, d);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
